// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle RV32I control sequencer.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, waits on the
// fetch and data handshakes, traps illegal encodings and counts retirements.
// Optional feature: define CTRL_TIMEOUT_EN to bound the FETCH/MEM waits to
// MEM_TIMEOUT cycles, after which the sequencer traps with a timeout code.
module rv_multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_vld,
  input  logic             data_vld,
  input  logic             br_eq,
  input  logic             br_lt,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [2:0]       imm_sel,
  output logic             a_sel,
  output logic             b_sel,
  output logic [3:0]       alu_sel,
  output logic             alu_we,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_wen,
  output logic [1:0]       wb_sel,
  output logic             br_un,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_IALU  = 5'b00100;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_BR    = 5'b11000;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_JAL   = 5'b11011;

  state_t             state_reg, state_next;
  logic [1:0]         fault_code_reg, fault_code_next;
  logic [CNT_W-1:0]   instret_reg;
  logic               retire;
  logic               legal;
  logic               timeout;

  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = instr[6:2];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // Register indices are consumed by the datapath, not by the sequencer.
  logic unused_instr;
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  // ALU function from funct3 plus the SUB/SRA modifier bit.
  function automatic logic [3:0] alu_fn(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'b000:  alu_fn = alt ? 4'd1 : 4'd0;
      3'b001:  alu_fn = 4'd5;
      3'b010:  alu_fn = 4'd8;
      3'b011:  alu_fn = 4'd9;
      3'b100:  alu_fn = 4'd4;
      3'b101:  alu_fn = alt ? 4'd7 : 4'd6;
      3'b110:  alu_fn = 4'd3;
      default: alu_fn = 4'd2;
    endcase
  endfunction

  // Legality check of the full instruction word.
  always_comb begin
    legal = 1'b0;
    case (opc)
      OP_R:    legal = (f7 == 7'h00) ||
                       ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OP_IALU: begin
        if (f3 == 3'b001)      legal = (f7 == 7'h00);
        else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                   legal = 1'b1;
      end
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      OP_BR:   legal = (f3 != 3'b010) && (f3 != 3'b011);
      default: legal = 1'b0;
    endcase
    if (instr[1:0] != 2'b11) legal = 1'b0;
  end

`ifdef CTRL_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  logic [WAIT_W-1:0] wait_cnt_reg;

  assign timeout = (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1));

  // Wait counter: restarts whenever FETCH or MEM is entered, counts while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt_reg <= '0;
    else if (((state_reg == S_FETCH) || (state_reg == S_MEM)) && (state_next == state_reg))
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    else
      wait_cnt_reg <= '0;
  end
`else
  // The wait bound only matters when timeouts are built in.
  localparam int unused_mem_timeout = MEM_TIMEOUT;
  assign timeout = 1'b0;
`endif

  // State, trap code and retirement counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_FETCH;
      fault_code_reg <= 2'd0;
      instret_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      fault_code_reg <= fault_code_next;
      if (retire) instret_reg <= instret_reg + 1'b1;
    end
  end

  // Next-state and state-decoded outputs; everything stays 0 while rst is high.
  always_comb begin
    state_next      = state_reg;
    fault_code_next = fault_code_reg;
    retire          = 1'b0;
    imem_req        = 1'b0;
    ir_we           = 1'b0;
    pc_we           = 1'b0;
    pc_sel          = 1'b0;
    imm_sel         = 3'd0;
    a_sel           = 1'b0;
    b_sel           = 1'b0;
    alu_sel         = 4'd0;
    alu_we          = 1'b0;
    mem_rd          = 1'b0;
    mem_wr          = 1'b0;
    reg_wen         = 1'b0;
    wb_sel          = 2'd0;
    br_un           = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_vld) begin
            ir_we      = 1'b1;
            state_next = S_DECODE;
          end else if (timeout) begin
            state_next      = S_TRAP;
            fault_code_next = 2'd2;
          end
        end
        S_DECODE: begin
          if (legal) state_next = S_EXEC;
          else begin
            state_next      = S_TRAP;
            fault_code_next = 2'd1;
          end
        end
        S_EXEC: begin
          alu_we     = 1'b1;
          state_next = S_WB;
          case (opc)
            OP_R: begin
              imm_sel = 3'd6;
              alu_sel = alu_fn(f3, instr[30]);
            end
            OP_IALU: begin
              imm_sel = ((f3 == 3'b001) || (f3 == 3'b101)) ? 3'd2 : 3'd1;
              b_sel   = 1'b1;
              alu_sel = alu_fn(f3, instr[30] && (f3 == 3'b101));
            end
            OP_LOAD: begin
              imm_sel    = 3'd1;
              b_sel      = 1'b1;
              state_next = S_MEM;
            end
            OP_STORE: begin
              imm_sel    = 3'd4;
              b_sel      = 1'b1;
              state_next = S_MEM;
            end
            OP_LUI: begin
              b_sel   = 1'b1;
              alu_sel = 4'd10;
            end
            OP_AUIPC: begin
              a_sel = 1'b1;
              b_sel = 1'b1;
            end
            OP_JAL: begin
              imm_sel = 3'd5;
              a_sel   = 1'b1;
              b_sel   = 1'b1;
            end
            OP_JALR: begin
              imm_sel = 3'd1;
              b_sel   = 1'b1;
            end
            OP_BR: begin
              imm_sel    = 3'd3;
              a_sel      = 1'b1;
              b_sel      = 1'b1;
              pc_we      = 1'b1;
              br_un      = f3[1];
              retire     = 1'b1;
              state_next = S_FETCH;
              case (f3)
                3'b000:         pc_sel = br_eq;
                3'b001:         pc_sel = !br_eq;
                3'b100, 3'b110: pc_sel = br_lt;
                3'b101, 3'b111: pc_sel = !br_lt;
                default:        pc_sel = 1'b0;
              endcase
            end
            default: state_next = S_FETCH;
          endcase
        end
        S_MEM: begin
          if (opc == OP_LOAD) begin
            mem_rd = 1'b1;
            if (data_vld) state_next = S_WB;
          end else begin
            mem_wr = 1'b1;
            if (data_vld) begin
              pc_we      = 1'b1;
              retire     = 1'b1;
              state_next = S_FETCH;
            end
          end
          if (!data_vld && timeout) begin
            state_next      = S_TRAP;
            fault_code_next = 2'd3;
          end
        end
        S_WB: begin
          reg_wen    = 1'b1;
          pc_we      = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
          if (opc == OP_LOAD)                         wb_sel = 2'd2;
          else if ((opc == OP_JAL) || (opc == OP_JALR)) begin
            wb_sel = 2'd0;
            pc_sel = 1'b1;
          end else                                    wb_sel = 2'd1;
        end
        default: state_next = S_TRAP;
      endcase
    end
  end

  assign fault      = (state_reg == S_TRAP);
  assign fault_code = fault_code_reg;
  assign instret    = instret_reg;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: a cycle-by-cycle vector table for
// the common instruction classes, plus hand-written sequences for trap,
// store wait/timeout, counter wrap (CNT_W=4) and asynchronous reset.
module tb_rv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        imem_vld, data_vld, br_eq, br_lt;
  logic        imem_req, ir_we, pc_we, pc_sel, a_sel, b_sel, alu_we;
  logic        mem_rd, mem_wr, reg_wen, br_un, fault;
  logic [2:0]  imm_sel;
  logic [3:0]  alu_sel;
  logic [1:0]  wb_sel, fault_code;
  logic [3:0]  instret;

  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.CNT_W(4), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_vld(imem_vld), .data_vld(data_vld),
    .br_eq(br_eq), .br_lt(br_lt), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .imm_sel(imm_sel), .a_sel(a_sel), .b_sel(b_sel), .alu_sel(alu_sel),
    .alu_we(alu_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wen(reg_wen), .wb_sel(wb_sel),
    .br_un(br_un), .fault(fault), .fault_code(fault_code), .instret(instret)
  );

  typedef struct packed {
    logic       imem_req, ir_we, pc_we, pc_sel;
    logic [2:0] imm_sel;
    logic       a_sel, b_sel;
    logic [3:0] alu_sel;
    logic       alu_we, mem_rd, mem_wr, reg_wen;
    logic [1:0] wb_sel;
    logic       br_un, fault;
    logic [1:0] fault_code;
    logic [3:0] instret;
  } outs_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        iv, dv, eq, lt;
    outs_t       exp;
  } vec_t;

  outs_t act;
  assign act = {imem_req, ir_we, pc_we, pc_sel, imm_sel, a_sel, b_sel, alu_sel,
                alu_we, mem_rd, mem_wr, reg_wen, wb_sel, br_un, fault, fault_code, instret};

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  localparam logic [31:0] I_ADD  = 32'h00208033;
  localparam logic [31:0] I_SUB  = 32'h40208033;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_BGEU = 32'h0020F463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_SRAI = 32'h4020D093;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_BAD  = 32'h0000000B;

  function automatic outs_t mk(logic req, logic irw, logic pcw, logic pcs, logic [2:0] imm,
                               logic as, logic bs, logic [3:0] alu, logic alw, logic rd,
                               logic wr, logic rw, logic [1:0] wb, logic bu, logic [3:0] c);
    outs_t o;
    o = '{imem_req: req, ir_we: irw, pc_we: pcw, pc_sel: pcs, imm_sel: imm, a_sel: as,
          b_sel: bs, alu_sel: alu, alu_we: alw, mem_rd: rd, mem_wr: wr, reg_wen: rw,
          wb_sel: wb, br_un: bu, fault: 1'b0, fault_code: 2'd0, instret: c};
    return o;
  endfunction

  function automatic outs_t o_idle(logic [3:0] c);
    return mk(0,0,0,0,3'd0,0,0,4'd0,0,0,0,0,2'd0,0,c);
  endfunction
  function automatic outs_t o_fetch(logic [3:0] c);
    return mk(1,1,0,0,3'd0,0,0,4'd0,0,0,0,0,2'd0,0,c);
  endfunction
  function automatic outs_t o_exec(logic [2:0] imm, logic as, logic bs, logic [3:0] alu, logic [3:0] c);
    return mk(0,0,0,0,imm,as,bs,alu,1,0,0,0,2'd0,0,c);
  endfunction
  function automatic outs_t o_wb(logic pcs, logic [1:0] wb, logic [3:0] c);
    return mk(0,0,1,pcs,3'd0,0,0,4'd0,0,0,0,1,wb,0,c);
  endfunction
  function automatic outs_t o_trap(logic [1:0] code, logic [3:0] c);
    outs_t o;
    o = o_idle(c);
    o.fault = 1'b1;
    o.fault_code = code;
    return o;
  endfunction

  task automatic add(input string nm, input logic [31:0] ins, input logic iv, input logic dv,
                     input logic eq, input logic lt, input outs_t e);
    vec_t v;
    v.name = nm; v.ins = ins; v.iv = iv; v.dv = dv; v.eq = eq; v.lt = lt; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input outs_t e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int e);
    total++;
    if (got != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // ---------------- vector table ----------------
    add("add.fetch", I_ADD, 1,0,0,0, o_fetch(0));
    add("add.dec",   I_ADD, 1,0,0,0, o_idle(0));
    add("add.exec",  I_ADD, 1,0,0,0, o_exec(3'd6,0,0,4'd0,0));
    add("add.wb",    I_ADD, 1,0,0,0, o_wb(0,2'd1,0));
    add("sub.fetch", I_SUB, 1,0,0,0, o_fetch(1));
    add("sub.dec",   I_SUB, 1,0,0,0, o_idle(1));
    add("sub.exec",  I_SUB, 1,0,0,0, o_exec(3'd6,0,0,4'd1,1));
    add("sub.wb",    I_SUB, 1,0,0,0, o_wb(0,2'd1,1));
    add("lw.fetch",  I_LW,  1,0,0,0, o_fetch(2));
    add("lw.dec",    I_LW,  1,0,0,0, o_idle(2));
    add("lw.exec",   I_LW,  1,0,0,0, o_exec(3'd1,0,1,4'd0,2));
    add("lw.mem0",   I_LW,  1,0,0,0, mk(0,0,0,0,3'd0,0,0,4'd0,0,1,0,0,2'd0,0,2));
    add("lw.mem1",   I_LW,  1,0,0,0, mk(0,0,0,0,3'd0,0,0,4'd0,0,1,0,0,2'd0,0,2));
    add("lw.mem2",   I_LW,  1,0,0,0, mk(0,0,0,0,3'd0,0,0,4'd0,0,1,0,0,2'd0,0,2));
    add("lw.mem3",   I_LW,  1,1,0,0, mk(0,0,0,0,3'd0,0,0,4'd0,0,1,0,0,2'd0,0,2));
    add("lw.wb",     I_LW,  1,0,0,0, o_wb(0,2'd2,2));
    add("bgeu.fetch",I_BGEU,1,0,0,0, o_fetch(3));
    add("bgeu.dec",  I_BGEU,1,0,0,0, o_idle(3));
    add("bgeu.exec", I_BGEU,1,0,0,0, mk(0,0,1,1,3'd3,1,1,4'd0,1,0,0,0,2'd0,1,3));
    add("bne.fetch", I_BNE, 1,0,1,0, o_fetch(4));
    add("bne.dec",   I_BNE, 1,0,1,0, o_idle(4));
    add("bne.exec",  I_BNE, 1,0,1,0, mk(0,0,1,0,3'd3,1,1,4'd0,1,0,0,0,2'd0,0,4));
    add("addi.wait", I_ADDI,0,0,0,0, mk(1,0,0,0,3'd0,0,0,4'd0,0,0,0,0,2'd0,0,5));
    add("addi.fetch",I_ADDI,1,0,0,0, o_fetch(5));
    add("addi.dec",  I_ADDI,1,0,0,0, o_idle(5));
    add("addi.exec", I_ADDI,1,0,0,0, o_exec(3'd1,0,1,4'd0,5));
    add("addi.wb",   I_ADDI,1,0,0,0, o_wb(0,2'd1,5));
    add("jal.fetch", I_JAL, 1,0,0,0, o_fetch(6));
    add("jal.dec",   I_JAL, 1,0,0,0, o_idle(6));
    add("jal.exec",  I_JAL, 1,0,0,0, o_exec(3'd5,1,1,4'd0,6));
    add("jal.wb",    I_JAL, 1,0,0,0, o_wb(1,2'd0,6));
    add("sw.fetch",  I_SW,  1,0,0,0, o_fetch(7));
    add("sw.dec",    I_SW,  1,0,0,0, o_idle(7));
    add("sw.exec",   I_SW,  1,0,0,0, o_exec(3'd4,0,1,4'd0,7));
    add("sw.mem",    I_SW,  1,1,0,0, mk(0,0,1,0,3'd0,0,0,4'd0,0,0,1,0,2'd0,0,7));
    add("srai.fetch",I_SRAI,1,0,0,0, o_fetch(8));
    add("srai.dec",  I_SRAI,1,0,0,0, o_idle(8));
    add("srai.exec", I_SRAI,1,0,0,0, o_exec(3'd2,0,1,4'd7,8));
    add("srai.wb",   I_SRAI,1,0,0,0, o_wb(0,2'd1,8));
    add("lui.fetch", I_LUI, 1,0,0,0, o_fetch(9));
    add("lui.dec",   I_LUI, 1,0,0,0, o_idle(9));
    add("lui.exec",  I_LUI, 1,0,0,0, o_exec(3'd0,0,1,4'd10,9));
    add("lui.wb",    I_LUI, 1,0,0,0, o_wb(0,2'd1,9));

    // ---------------- reset ----------------
    rst = 1'b1; instr = I_ADD; imem_vld = 1'b1; data_vld = 1'b0; br_eq = 1'b0; br_lt = 1'b0;
    @(negedge clk);
    check("reset_state", o_idle(0));
    next_cycle();
    rst = 1'b0;

    // ---------------- table-driven run ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      instr = vecs[i].ins; imem_vld = vecs[i].iv; data_vld = vecs[i].dv;
      br_eq = vecs[i].eq;  br_lt = vecs[i].lt;
      @(negedge clk);
      check(vecs[i].name, vecs[i].exp);
      $display("vec %0d %s instr=%h out=%h", i, vecs[i].name, vecs[i].ins, act);
      next_cycle();
    end

    // ---------------- illegal instruction traps ----------------
    instr = I_BAD; imem_vld = 1'b1; data_vld = 1'b0; br_eq = 1'b0; br_lt = 1'b0;
    @(negedge clk); check("bad.fetch", o_fetch(10)); next_cycle();
    @(negedge clk); check("bad.dec", o_idle(10));    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); check("bad.trap", o_trap(2'd1, 10)); next_cycle();
    end
    $display("illegal instr=%h fault=%0d code=%0d", instr, fault, fault_code);

    rst = 1'b1;
    @(negedge clk); check("reset_clears_trap", o_idle(0));
    next_cycle();
    rst = 1'b0;

    // ---------------- store with no acknowledge ----------------
    instr = I_SW; imem_vld = 1'b1; data_vld = 1'b0;
    @(negedge clk); check("swt.fetch", o_fetch(0));                next_cycle();
    @(negedge clk); check("swt.dec", o_idle(0));                   next_cycle();
    @(negedge clk); check("swt.exec", o_exec(3'd4,0,1,4'd0,0));    next_cycle();
    n = 0;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (!mem_wr || fault) break;
      n++;
      next_cycle();
    end
`ifdef CTRL_TIMEOUT_EN
    chk_int("swt.wait_cycles", n, 16);
    check("swt.trap", o_trap(2'd3, 0));
    next_cycle();
`else
    chk_int("swt.wait_cycles", n, 110);
    @(negedge clk);
    check("swt.still_waiting", mk(0,0,0,0,3'd0,0,0,4'd0,0,0,1,0,2'd0,0,0));
    next_cycle();
`endif
    $display("store wait mem_wr_cycles=%0d fault=%0d code=%0d", n, fault, fault_code);

    rst = 1'b1;
    next_cycle();
    rst = 1'b0;

    // ---------------- counter wrap (CNT_W=4) ----------------
    instr = I_ADDI; imem_vld = 1'b1; data_vld = 1'b0;
    for (int k = 0; k < 64; k++) @(posedge clk);
    #1;
    @(negedge clk); check("wrap.after16", o_fetch(0));
    for (int k = 0; k < 4; k++) @(posedge clk);
    #1;
    @(negedge clk); check("wrap.after17", o_fetch(1)); next_cycle();
    $display("counter after 17 instructions instret=%0d", instret);

    // ---------------- asynchronous reset mid-EXEC ----------------
    @(negedge clk); check("ar.dec", o_idle(1));                    next_cycle();
    @(negedge clk); check("ar.exec", o_exec(3'd1,0,1,4'd0,1));
    #1 rst = 1'b1;
    #1 check("ar.async_zero", o_idle(0));
    next_cycle();
    @(negedge clk); check("ar.held", o_idle(0));
    next_cycle();
    rst = 1'b0;
    @(negedge clk); check("ar.first_fetch", o_fetch(0));
    $display("async reset mid-exec instret=%0d imem_req=%0d", instret, imem_req);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
